// File: rtl/spi_slave_regs.sv
// SPI mode-3 register responder with a system-bus port onto the same register file.
// Optional streaming (auto-increment across data words) is enabled by defining SPI_SLV_STREAM_EN.
module spi_slave_regs #(
  parameter int HW = 16,
  parameter int AW = 7,
  parameter int DW = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        spi_cs_i,
  input  logic        spi_clk_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic        spi_miso_t,
  input  logic [31:0] sys_addr,
  input  logic [31:0] sys_wdata,
  input  logic        sys_wen,
  input  logic        sys_ren,
  output logic [31:0] sys_rdata,
  output logic        sys_ack,
  output logic        sys_err,
  output logic        sts_busy_o,
  output logic        sts_abort_o
);

  localparam int NREG = 1 << AW;
  localparam int CW   = $clog2(((HW > DW) ? HW : DW) + 1);
  localparam logic [CW-1:0] C_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_bcnt;
  logic [AW-1:0]   r_addr;
  logic            r_rd;
  logic            r_miso_o;
  logic            r_miso_t;
  logic            r_abort;
  logic [HW-1:0]   r_hdr_sr;
  logic [DW-1:0]   r_data_sr;
  logic [DW-1:0]   r_regs [NREG];
  logic            r_ack;
  logic [31:0]     r_rdata;
  logic [2:0]      r_cs_sync;
  logic [2:0]      r_clk_sync;
  logic [1:0]      r_mosi_sync;

  logic            w_mosi;
  logic            w_sclk_rise;
  logic            w_sclk_fall;
  logic            w_cs_rise;
  logic            w_cs_fall;
  logic [HW-1:0]   w_hdr_next;
  logic [DW-1:0]   w_data_next;
  logic            w_last_hdr;
  logic            w_last_data;
  logic            w_spi_we;
  logic            w_bus_ok;
  logic [AW-1:0]   w_bus_idx;
  logic            w_unused;

  // CS sync resets low so a frame already in flight at reset release is never seen as a CS fall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cs_sync   <= 3'b000;
      r_clk_sync  <= 3'b111;
      r_mosi_sync <= 2'b00;
    end else begin
      r_cs_sync   <= {r_cs_sync[1:0], spi_cs_i};
      r_clk_sync  <= {r_clk_sync[1:0], spi_clk_i};
      r_mosi_sync <= {r_mosi_sync[0], spi_mosi_i};
    end
  end

  assign w_mosi      = r_mosi_sync[1];
  assign w_sclk_rise = r_clk_sync[1] & ~r_clk_sync[2];
  assign w_sclk_fall = ~r_clk_sync[1] & r_clk_sync[2];
  assign w_cs_rise   = r_cs_sync[1] & ~r_cs_sync[2];
  assign w_cs_fall   = ~r_cs_sync[1] & r_cs_sync[2];
  assign w_hdr_next  = {r_hdr_sr[HW-2:0], w_mosi};
  assign w_data_next = {r_data_sr[DW-2:0], w_mosi};
  assign w_last_hdr  = (r_bcnt == CW'(HW - 1));
  assign w_last_data = (r_bcnt == CW'(DW - 1));
  assign w_spi_we    = (r_state == S_DATA) && w_sclk_rise && !w_cs_rise && !r_rd && w_last_data;

`ifdef SPI_SLV_STREAM_EN
  logic [AW-1:0] w_addr_inc;
  assign w_addr_inc = r_addr + AW'(1);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_bcnt   <= '0;
      r_addr   <= '0;
      r_rd     <= 1'b0;
      r_miso_o <= 1'b0;
      r_miso_t <= 1'b1;
      r_abort  <= 1'b0;
    end else begin
      r_abort <= 1'b0;
      if (w_cs_rise) begin
        r_abort  <= (r_state == S_HDR) || (r_state == S_DATA);
        r_state  <= S_IDLE;
        r_miso_o <= 1'b0;
        r_miso_t <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_cs_fall) begin
              r_state <= S_HDR;
              r_bcnt  <= '0;
            end
          end
          S_HDR: begin
            if (w_sclk_rise) begin
              r_bcnt <= r_bcnt + C_ONE;
              if (w_last_hdr) begin
                r_state  <= S_DATA;
                r_bcnt   <= '0;
                r_addr   <= w_hdr_next[AW-1:0];
                r_rd     <= w_hdr_next[HW-1];
                r_miso_t <= ~w_hdr_next[HW-1];
              end
            end
          end
          S_DATA: begin
            if (r_rd && w_sclk_fall) r_miso_o <= r_data_sr[DW-1];
            if (w_sclk_rise) begin
              r_bcnt <= r_bcnt + C_ONE;
              if (w_last_data) begin
`ifdef SPI_SLV_STREAM_EN
                r_bcnt <= '0;
                r_addr <= w_addr_inc;
`else
                r_state  <= S_DONE;
                r_miso_o <= 1'b0;
                r_miso_t <= 1'b1;
`endif
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Shift registers carry no reset; their contents are only consumed after a full reload.
  always_ff @(posedge clk_i) begin
    if (r_state == S_HDR && w_sclk_rise) begin
      r_hdr_sr <= w_hdr_next;
      if (w_last_hdr) r_data_sr <= r_regs[w_hdr_next[AW-1:0]];
    end else if (r_state == S_DATA) begin
      if (!r_rd && w_sclk_rise) r_data_sr <= w_data_next;
      else if (r_rd && w_sclk_fall) r_data_sr <= {r_data_sr[DW-2:0], 1'b0};
`ifdef SPI_SLV_STREAM_EN
      else if (r_rd && w_sclk_rise && w_last_data) r_data_sr <= r_regs[w_addr_inc];
`endif
    end
  end

  assign w_bus_ok  = (sys_addr[19:AW+2] == '0);
  assign w_bus_idx = sys_addr[AW+1:2];

  // SPI write is applied after the bus write so it takes priority on a same-cycle collision.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (sys_wen && w_bus_ok) r_regs[w_bus_idx] <= sys_wdata[DW-1:0];
      if (w_spi_we) r_regs[r_addr] <= w_data_next;
      r_ack   <= sys_wen | sys_ren;
      r_rdata <= (sys_ren && w_bus_ok) ? {{(32-DW){1'b0}}, r_regs[w_bus_idx]} : '0;
    end
  end

  assign spi_miso_o  = r_miso_o;
  assign spi_miso_t  = r_miso_t;
  assign sys_rdata   = r_rdata;
  assign sys_ack     = r_ack;
  assign sys_err     = 1'b0;
  assign sts_busy_o  = (r_state == S_HDR) || (r_state == S_DATA);
  assign sts_abort_o = r_abort;
  assign w_unused    = ^{sys_addr[31:20], sys_addr[1:0], sys_wdata[31:DW]};

endmodule
